// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage 16-bit CPU.
// Holds the opcode map, instruction field positions and hazard controller state encoding.
package cpu_pkg;

  localparam int INSTR_W   = 16;
  localparam int OPCODE_W  = 5;
  localparam int REG_IDX_W = 3;

  // Instruction field positions: [15:11] opcode, [10:8] Rs, [7:5] Rt
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 11;
  localparam int RS_MSB = 10;
  localparam int RS_LSB = 8;
  localparam int RT_MSB = 7;
  localparam int RT_LSB = 5;

  typedef logic [OPCODE_W-1:0]  opcode_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam opcode_t OP_ADD  = 5'h00;
  localparam opcode_t OP_SUB  = 5'h01;
  localparam opcode_t OP_AND  = 5'h02;
  localparam opcode_t OP_OR   = 5'h03;
  localparam opcode_t OP_XOR  = 5'h04;
  localparam opcode_t OP_SLT  = 5'h05;
  localparam opcode_t OP_SLL  = 5'h06;
  localparam opcode_t OP_ADDI = 5'h08;
  localparam opcode_t OP_ANDI = 5'h09;
  localparam opcode_t OP_LUI  = 5'h0A;
  localparam opcode_t OP_LW   = 5'h10;
  localparam opcode_t OP_SW   = 5'h11;
  localparam opcode_t OP_BEQ  = 5'h18;
  localparam opcode_t OP_BNE  = 5'h19;
  localparam opcode_t OP_JMP  = 5'h1A;
  localparam opcode_t OP_JR   = 5'h1B;
  localparam opcode_t OP_JAL  = 5'h1C;
  localparam opcode_t OP_NOP  = 5'h1E;
  localparam opcode_t OP_HALT = 5'h1F;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_controller_reg_use_decode.sv
// Opcode decode telling which source register fields an instruction actually reads.
// Shared with the forwarding unit, which uses usesRt_o to qualify its Rt compare.
module reg_use_decode
  import cpu_pkg::*;
(
  input  opcode_t opcode_i,
  output logic    usesRs_o,
  output logic    usesRt_o
);

  // Unlisted opcodes are illegal and execute as NOPs, so they read nothing
  always_comb begin
    usesRs_o = 1'b0;
    usesRt_o = 1'b0;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
      OP_SW, OP_BEQ, OP_BNE: begin
        usesRs_o = 1'b1;
        usesRt_o = 1'b1;
      end
      OP_SLL, OP_ADDI, OP_ANDI, OP_LW, OP_JR: begin
        usesRs_o = 1'b1;
      end
      default: begin
        usesRs_o = 1'b0;
        usesRt_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory freezes and HALT.
// Drives all pipeline-register enables/flushes and a saturating stall-cycle counter.
module hazard_controller
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] ifid_Instr,
  input  logic               idex_MemRead,
  input  logic               idex_RegWriteEn,
  input  reg_idx_t           idex_RegD,
  input  logic               ex_branchTaken,
  input  logic               mem_stall,
  input  logic               halt_detect,
  output logic               pc_WriteEn,
  output logic               ifid_WriteEn,
  output logic               ifid_Flush,
  output logic               idex_Flush,
  output logic               exmem_WriteEn,
  output logic               memwb_Flush,
  output logic               halted,
  output logic               timeout_err,
  output logic [15:0]        stall_cycles
);

  localparam int               CNT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d, waitCntInc;
  logic             halted_q, halted_d;
  logic             timeoutErr_q, timeoutErr_d;
  logic [15:0]      stallCnt_q, stallCnt_d;

  opcode_t           idOpcode;
  reg_idx_t          idRs, idRt;
  logic              usesRs, usesRt;
  logic              rsHit, rtHit, loadUse;
  logic [RT_LSB-1:0] unusedInstrLow;

  assign idOpcode       = ifid_Instr[OP_MSB:OP_LSB];
  assign idRs           = ifid_Instr[RS_MSB:RS_LSB];
  assign idRt           = ifid_Instr[RT_MSB:RT_LSB];
  assign unusedInstrLow = ifid_Instr[RT_LSB-1:0];

  reg_use_decode u_regUseDecode (
    .opcode_i (idOpcode),
    .usesRs_o (usesRs),
    .usesRt_o (usesRt)
  );

  // Register 0 is deliberately not exempt from the compare
  assign rsHit   = usesRs && (idex_RegD == idRs);
  assign rtHit   = usesRt && (idex_RegD == idRt);
  assign loadUse = (state_q == RUN) && idex_MemRead && idex_RegWriteEn && (rsHit || rtHit);

  assign waitCntInc = waitCnt_q + CNT_W'(1);

  // Timeout fires on the edge where the wait count becomes MEM_TIMEOUT
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = waitCnt_q;
    halted_d     = halted_q;
    timeoutErr_d = timeoutErr_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d   = MEM_WAIT;
          waitCnt_d = '0;
        end else if (halt_detect) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
        end else begin
          waitCnt_d = waitCntInc;
          if (waitCntInc == WAIT_LIMIT) begin
            state_d      = HALTED;
            halted_d     = 1'b1;
            timeoutErr_d = 1'b1;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // A branch seen during mem_stall is ignored here; EX holds it until the stall clears
  always_comb begin
    pc_WriteEn    = 1'b1;
    ifid_WriteEn  = 1'b1;
    exmem_WriteEn = 1'b1;
    ifid_Flush    = 1'b0;
    idex_Flush    = 1'b0;
    memwb_Flush   = 1'b0;
    if (rst) begin
      pc_WriteEn    = 1'b0;
      ifid_WriteEn  = 1'b0;
      exmem_WriteEn = 1'b0;
      ifid_Flush    = 1'b1;
      idex_Flush    = 1'b1;
      memwb_Flush   = 1'b1;
    end else if (state_q == HALTED) begin
      pc_WriteEn    = 1'b0;
      ifid_WriteEn  = 1'b0;
      exmem_WriteEn = 1'b0;
    end else if (mem_stall) begin
      pc_WriteEn    = 1'b0;
      ifid_WriteEn  = 1'b0;
      exmem_WriteEn = 1'b0;
      memwb_Flush   = 1'b1;
    end else if (ex_branchTaken) begin
      ifid_Flush = 1'b1;
      idex_Flush = 1'b1;
    end else if (loadUse) begin
      pc_WriteEn   = 1'b0;
      ifid_WriteEn = 1'b0;
      idex_Flush   = 1'b1;
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (!pc_WriteEn && (state_q != HALTED) && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      waitCnt_q    <= '0;
      halted_q     <= 1'b0;
      timeoutErr_q <= 1'b0;
      stallCnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      halted_q     <= halted_d;
      timeoutErr_q <= timeoutErr_d;
      stallCnt_q   <= stallCnt_d;
    end
  end

  assign halted       = halted_q;
  assign timeout_err  = timeoutErr_q;
  assign stall_cycles = stallCnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: two instances with different MEM_TIMEOUT
// checked every cycle against a behavioural model, plus directed literal expectations.
module tb_hazard_controller;
  import cpu_pkg::*;

  localparam int NUM_DUT       = 2;
  localparam int TIMEOUT_A     = 4;
  localparam int TIMEOUT_B     = 64;
  localparam int RANDOM_CYCLES = 3000;
  localparam int SAT_CYCLES    = 65540;

  // Control vector order: {pc_WriteEn, ifid_WriteEn, ifid_Flush, idex_Flush, exmem_WriteEn, memwb_Flush}
  localparam logic [5:0] CTL_NORMAL  = 6'b110010;
  localparam logic [5:0] CTL_RESET   = 6'b001101;
  localparam logic [5:0] CTL_HALTED  = 6'b000000;
  localparam logic [5:0] CTL_MEMSTL  = 6'b000001;
  localparam logic [5:0] CTL_BRANCH  = 6'b111110;
  localparam logic [5:0] CTL_LOADUSE = 6'b000110;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ifidInstr;
  logic        idexMemRead, idexRegWriteEn;
  logic [2:0]  idexRegD;
  logic        exBranchTaken, memStall, haltDetect;

  logic        pcWeA, ifidWeA, ifidFlA, idexFlA, exmemWeA, memwbFlA, haltedA, timeoutA;
  logic        pcWeB, ifidWeB, ifidFlB, idexFlB, exmemWeB, memwbFlB, haltedB, timeoutB;
  logic [15:0] stallA, stallB;
  logic [5:0]  ctlA, ctlB;

  int checkCount = 0;
  int passCount  = 0;

  // Model: mode 0 running, 1 waiting on memory, 2 halted
  int  mMode    [NUM_DUT];
  int  mWait    [NUM_DUT];
  bit  mTimeout [NUM_DUT];
  int  mStalls  [NUM_DUT];
  bit  modelValid = 1'b0;
  bit  usesRsTab [32];
  bit  usesRtTab [32];

  opcode_t bothOps  [9]  = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SW, OP_BEQ, OP_BNE};
  opcode_t rsOnlyOps[5]  = '{OP_SLL, OP_ADDI, OP_ANDI, OP_LW, OP_JR};
  opcode_t noneOps  [5]  = '{OP_LUI, OP_JMP, OP_JAL, OP_NOP, OP_HALT};

  always #5 clk = ~clk;

  hazard_controller #(.MEM_TIMEOUT(TIMEOUT_A)) dutA (
    .clk(clk), .rst(rst), .ifid_Instr(ifidInstr), .idex_MemRead(idexMemRead),
    .idex_RegWriteEn(idexRegWriteEn), .idex_RegD(idexRegD), .ex_branchTaken(exBranchTaken),
    .mem_stall(memStall), .halt_detect(haltDetect), .pc_WriteEn(pcWeA), .ifid_WriteEn(ifidWeA),
    .ifid_Flush(ifidFlA), .idex_Flush(idexFlA), .exmem_WriteEn(exmemWeA), .memwb_Flush(memwbFlA),
    .halted(haltedA), .timeout_err(timeoutA), .stall_cycles(stallA)
  );

  hazard_controller #(.MEM_TIMEOUT(TIMEOUT_B)) dutB (
    .clk(clk), .rst(rst), .ifid_Instr(ifidInstr), .idex_MemRead(idexMemRead),
    .idex_RegWriteEn(idexRegWriteEn), .idex_RegD(idexRegD), .ex_branchTaken(exBranchTaken),
    .mem_stall(memStall), .halt_detect(haltDetect), .pc_WriteEn(pcWeB), .ifid_WriteEn(ifidWeB),
    .ifid_Flush(ifidFlB), .idex_Flush(idexFlB), .exmem_WriteEn(exmemWeB), .memwb_Flush(memwbFlB),
    .halted(haltedB), .timeout_err(timeoutB), .stall_cycles(stallB)
  );

  assign ctlA = {pcWeA, ifidWeA, ifidFlA, idexFlA, exmemWeA, memwbFlA};
  assign ctlB = {pcWeB, ifidWeB, ifidFlB, idexFlB, exmemWeB, memwbFlB};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  function automatic logic [15:0] mkInstr(input opcode_t op, input logic [2:0] rs, input logic [2:0] rt);
    return {op, rs, rt, 5'b00000};
  endfunction

  function automatic int waitLimit(input int k);
    return (k == 0) ? TIMEOUT_A : TIMEOUT_B;
  endfunction

  // Expected combinational controls from the priority rules and current model mode
  function automatic logic [5:0] expectedCtl(input int k);
    logic [4:0] op;
    logic [2:0] rs, rt;
    bit hazard;
    op = ifidInstr[15:11];
    rs = ifidInstr[10:8];
    rt = ifidInstr[7:5];
    hazard = idexMemRead && idexRegWriteEn &&
             ((usesRsTab[op] && idexRegD == rs) || (usesRtTab[op] && idexRegD == rt));
    if (rst)                        return CTL_RESET;
    if (mMode[k] == 2)              return CTL_HALTED;
    if (memStall)                   return CTL_MEMSTL;
    if (exBranchTaken)              return CTL_BRANCH;
    if (hazard && mMode[k] == 0)    return CTL_LOADUSE;
    return CTL_NORMAL;
  endfunction

  task automatic modelStep(input int k, input bit pcEn);
    if (rst) begin
      mMode[k] = 0; mWait[k] = 0; mTimeout[k] = 1'b0; mStalls[k] = 0;
      return;
    end
    if (mMode[k] != 2 && !pcEn && mStalls[k] < 65535) mStalls[k]++;
    if (mMode[k] == 0) begin
      if (memStall) begin mMode[k] = 1; mWait[k] = 0; end
      else if (haltDetect) mMode[k] = 2;
    end else if (mMode[k] == 1) begin
      if (!memStall) mMode[k] = 0;
      else begin
        mWait[k]++;
        if (mWait[k] == waitLimit(k)) begin mMode[k] = 2; mTimeout[k] = 1'b1; end
      end
    end
  endtask

  // Every-cycle comparison against the model, then advance it to the next edge
  always @(negedge clk) begin
    logic [5:0]  gotCtl   [NUM_DUT];
    logic        gotHalt  [NUM_DUT];
    logic        gotTmo   [NUM_DUT];
    logic [15:0] gotStall [NUM_DUT];
    logic [5:0]  expCtl;
    gotCtl[0] = ctlA;    gotHalt[0] = haltedA; gotTmo[0] = timeoutA; gotStall[0] = stallA;
    gotCtl[1] = ctlB;    gotHalt[1] = haltedB; gotTmo[1] = timeoutB; gotStall[1] = stallB;
    for (int k = 0; k < NUM_DUT; k++) begin
      expCtl = expectedCtl(k);
      if (modelValid) begin
        checkOutput($sformatf("model dut%0d ctl", k), 32'(gotCtl[k]), 32'(expCtl));
        checkOutput($sformatf("model dut%0d halted", k), 32'(gotHalt[k]), 32'(mMode[k] == 2));
        checkOutput($sformatf("model dut%0d timeout_err", k), 32'(gotTmo[k]), 32'(mTimeout[k]));
        checkOutput($sformatf("model dut%0d stall_cycles", k), 32'(gotStall[k]), 32'(mStalls[k]));
      end
      modelStep(k, expCtl[5]);
    end
    if (rst) modelValid = 1'b1;
  end

  task automatic applyStimulus(input bit r, input logic [15:0] instr, input bit memRd,
                               input bit regWe, input logic [2:0] regD, input bit br,
                               input bit ms, input bit halt);
    @(posedge clk);
    #1;
    rst = r; ifidInstr = instr; idexMemRead = memRd; idexRegWriteEn = regWe;
    idexRegD = regD; exBranchTaken = br; memStall = ms; haltDetect = halt;
  endtask

  task automatic waitSample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int msLeft;
    opcode_t op;
    logic [2:0] regD, rs, rt;

    for (int i = 0; i < 32; i++) begin usesRsTab[i] = 1'b0; usesRtTab[i] = 1'b0; end
    foreach (bothOps[i])   begin usesRsTab[bothOps[i]] = 1'b1; usesRtTab[bothOps[i]] = 1'b1; end
    foreach (rsOnlyOps[i]) usesRsTab[rsOnlyOps[i]] = 1'b1;

    rst = 1'b1; ifidInstr = mkInstr(OP_NOP, 0, 0); idexMemRead = 0; idexRegWriteEn = 0;
    idexRegD = 0; exBranchTaken = 0; memStall = 0; haltDetect = 0;

    $display("[TB] reset and load-use directed checks");
    applyStimulus(1, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 0);
    applyStimulus(0, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 0);
    waitSample();
    checkOutput("reset ctl", 32'(ctlA), 32'(CTL_NORMAL));
    checkOutput("reset stall_cycles", 32'(stallA), 32'd0);
    checkOutput("reset halted", 32'(haltedA), 32'd0);
    checkOutput("reset timeout_err", 32'(timeoutA), 32'd0);

    applyStimulus(0, mkInstr(OP_ADD, 3, 5), 1, 1, 3, 0, 0, 0);
    waitSample();
    checkOutput("load-use rs ctl", 32'(ctlA), 32'(CTL_LOADUSE));
    applyStimulus(0, mkInstr(OP_ADD, 3, 5), 0, 1, 3, 0, 0, 0);
    waitSample();
    checkOutput("load-use bubble ctl", 32'(ctlA), 32'(CTL_NORMAL));
    checkOutput("load-use stall_cycles", 32'(stallA), 32'd1);

    applyStimulus(0, mkInstr(OP_ADDI, 1, 3), 1, 1, 3, 0, 0, 0);
    waitSample();
    checkOutput("rs-only rt match ctl", 32'(ctlA), 32'(CTL_NORMAL));
    applyStimulus(0, mkInstr(OP_ADD, 1, 3), 1, 1, 3, 0, 0, 0);
    waitSample();
    checkOutput("load-use rt ctl", 32'(ctlA), 32'(CTL_LOADUSE));
    applyStimulus(0, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 0);
    applyStimulus(0, mkInstr(OP_ADD, 0, 6), 1, 1, 0, 0, 0, 0);
    waitSample();
    checkOutput("load-use r0 ctl", 32'(ctlA), 32'(CTL_LOADUSE));
    applyStimulus(0, mkInstr(OP_ADD, 3, 5), 1, 1, 3, 1, 0, 0);
    waitSample();
    checkOutput("branch beats load-use ctl", 32'(ctlA), 32'(CTL_BRANCH));
    applyStimulus(0, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 0);
    waitSample();
    checkOutput("branch stall_cycles unchanged", 32'(stallA), 32'd3);

    $display("[TB] memory stall and timeout directed checks");
    applyStimulus(1, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(0, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 1, 1, 0);
      waitSample();
      checkOutput($sformatf("mem_stall cycle %0d ctl", c), 32'(ctlB), 32'(CTL_MEMSTL));
      checkOutput($sformatf("pre-timeout cycle %0d timeout_err", c), 32'(timeoutA), 32'd0);
    end
    applyStimulus(0, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 1, 0, 0);
    waitSample();
    checkOutput("held branch ctl", 32'(ctlB), 32'(CTL_BRANCH));
    checkOutput("mem_stall stall_cycles", 32'(stallB), 32'd5);
    checkOutput("timeout timeout_err", 32'(timeoutA), 32'd1);
    checkOutput("timeout halted", 32'(haltedA), 32'd1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 0);
      waitSample();
      checkOutput("post-timeout ctl", 32'(ctlA), 32'(CTL_HALTED));
      checkOutput("post-timeout stall_cycles", 32'(stallA), 32'd5);
    end

    $display("[TB] halt and reset directed checks");
    applyStimulus(1, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 0);
    applyStimulus(0, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 1);
    waitSample();
    checkOutput("halt_detect cycle halted", 32'(haltedA), 32'd0);
    applyStimulus(0, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 0);
    waitSample();
    checkOutput("halted flag", 32'(haltedA), 32'd1);
    checkOutput("halted ctl", 32'(ctlA), 32'(CTL_HALTED));
    applyStimulus(1, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 0);
    waitSample();
    checkOutput("reset-asserted ctl", 32'(ctlA), 32'(CTL_RESET));
    applyStimulus(0, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 0);
    waitSample();
    checkOutput("post-halt reset halted", 32'(haltedA), 32'd0);
    checkOutput("post-halt reset ctl", 32'(ctlA), 32'(CTL_NORMAL));
    checkOutput("post-halt reset stall_cycles", 32'(stallA), 32'd0);

    $display("[TB] randomized phase");
    msLeft = 0;
    for (int i = 0; i < RANDOM_CYCLES; i++) begin
      bit ms;
      if (msLeft > 0) begin ms = 1'b1; msLeft--; end
      else if ($urandom_range(0, 99) < 8) begin ms = 1'b1; msLeft = $urandom_range(0, 6); end
      else ms = 1'b0;
      case ($urandom_range(0, 3))
        0:       op = bothOps[$urandom_range(0, 8)];
        1:       op = rsOnlyOps[$urandom_range(0, 4)];
        2:       op = noneOps[$urandom_range(0, 4)];
        default: op = opcode_t'($urandom_range(0, 31));
      endcase
      regD = 3'($urandom_range(0, 7));
      rs   = ($urandom_range(0, 1) == 0) ? regD : 3'($urandom_range(0, 7));
      rt   = ($urandom_range(0, 1) == 0) ? regD : 3'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 99) < 2, mkInstr(op, rs, rt),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, regD,
                    $urandom_range(0, 5) == 0, ms, $urandom_range(0, 99) < 2);
    end

    $display("[TB] stall counter saturation");
    applyStimulus(1, mkInstr(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 0);
    applyStimulus(0, mkInstr(OP_ADD, 2, 4), 1, 1, 2, 0, 0, 0);
    for (int i = 0; i < SAT_CYCLES; i++) begin
      waitSample();
      if (i == 65534) checkOutput("saturation approach", 32'(stallA), 32'h0000FFFE);
      if (i == 65535) checkOutput("saturation reached", 32'(stallA), 32'h0000FFFF);
      if (i == SAT_CYCLES - 1) checkOutput("saturation held", 32'(stallB), 32'h0000FFFF);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
